// File: rtl/bcd_down_cnt3.sv
// ---------------------------------------------------------------------------
// bcd_down_cnt3 -- three-digit BCD countdown timer (999..000).
//
// A start value loaded through LOAD/LD_VAL counts down to zero, with the
// borrow rippling from the ones digit to the hundreds digit. START/STOP run
// and pause the count. PRESCALE sets how many CLK0 cycles pass per decrement.
// DONE pulses for one cycle on expiry. ERR pulses for one cycle when a LOAD
// carries a non-BCD digit.
//
// Optional feature: define AUTO_RELOAD_EN so that expiry reloads the last
// loaded start value and keeps running instead of stopping in ZERO.
// ---------------------------------------------------------------------------
module bcd_down_cnt3 #(
  parameter int PRESCALE = 1
) (
  input  logic        CLK0,
  input  logic        RST,
  input  logic        LOAD,
  input  logic [11:0] LD_VAL,
  input  logic        START,
  input  logic        STOP,
  output logic [3:0]  out0,
  output logic [3:0]  out1,
  output logic [3:0]  out2,
  output logic        RUN,
  output logic        DONE,
  output logic        ERR
);

  // Prescaler width; at least one bit, so that PRESCALE=1 still elaborates.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    ZERO    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [11:0]     value_q, value_d;
  logic [11:0]     reload_q, reload_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            run_d, done_d, err_d;

  logic            ld_ok;
  logic            tick;
  logic            at_one;
  logic            borrow0, borrow1;
  logic [3:0]      dec0, dec1, dec2;
  logic [11:0]     value_dec;

  // Decrement datapath: each digit wraps 0 -> 9 and borrows from the next
  // digit, so every digit always holds legal BCD.
  always_comb begin
    borrow0   = (value_q[3:0] == 4'd0);
    dec0      = borrow0 ? 4'd9 : value_q[3:0] - 4'd1;
    borrow1   = borrow0 && (value_q[7:4] == 4'd0);
    dec1      = borrow0 ? ((value_q[7:4] == 4'd0) ? 4'd9 : value_q[7:4] - 4'd1)
                        : value_q[7:4];
    dec2      = borrow1 ? ((value_q[11:8] == 4'd0) ? 4'd9 : value_q[11:8] - 4'd1)
                        : value_q[11:8];
    value_dec = {dec2, dec1, dec0};
  end

  assign ld_ok  = (LD_VAL[3:0] <= 4'd9) && (LD_VAL[7:4] <= 4'd9) &&
                  (LD_VAL[11:8] <= 4'd9);
  assign tick   = (state_q == RUNNING) && (presc_q == PRESC_LAST);
  assign at_one = (value_q == 12'h001);

  // Next-state and datapath decision; priority is LOAD > STOP > START > tick.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the if/else chain can leave one unassigned and infer a latch.
    state_d  = state_q;
    value_d  = value_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (LOAD) begin
      if (ld_ok) begin
        value_d  = LD_VAL;
        reload_d = LD_VAL;
        state_d  = IDLE;
        presc_d  = '0;
      end else begin
        // Rejected load freezes the whole counter for this edge.
        err_d = 1'b1;
      end
    end else if (STOP) begin
      // STOP consumes the edge even where it has no effect, so START+STOP
      // never starts the counter.
      if (state_q == RUNNING) begin
        state_d = PAUSED;
      end
    end else if (START && (state_q == IDLE || state_q == PAUSED) &&
                 (value_q != 12'h000)) begin
      // Prescaler is left alone: PAUSED resumes its phase, IDLE already has 0.
      state_d = RUNNING;
    end else if (state_q == RUNNING) begin
      if (tick) begin
        presc_d = '0;
        if (at_one) begin
          done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
          if (reload_q != 12'h000) begin
            value_d = reload_q;
          end else begin
            value_d = 12'h000;
            state_d = ZERO;
          end
`else
          value_d = 12'h000;
          state_d = ZERO;
`endif
        end else begin
          value_d = value_dec;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    run_d = (state_d == RUNNING);
  end

  // State, value, reload and pulse registers; reset clears everything.
  always_ff @(posedge CLK0 or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      value_q  <= 12'h000;
      reload_q <= 12'h000;
      presc_q  <= '0;
      RUN      <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, regardless of statement order.
      state_q  <= state_d;
      value_q  <= value_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      RUN      <= run_d;
      DONE     <= done_d;
      ERR      <= err_d;
    end
  end

  assign out0 = value_q[3:0];
  assign out1 = value_q[7:4];
  assign out2 = value_q[11:8];

endmodule

// File: tb/tb_bcd_down_cnt3.sv
// ---------------------------------------------------------------------------
// tb_bcd_down_cnt3 -- scoreboard bench for bcd_down_cnt3.
// Two instances share the inputs: one with PRESCALE=1 and one with PRESCALE=4.
// Stimulus drives on the falling edge and queues the expected outputs for
// the following rising edge; the monitor pops and compares 1 ns after that
// rising edge. Expiry expectations follow AUTO_RELOAD_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_bcd_down_cnt3;

  logic        CLK0;
  logic        RST;
  logic        LOAD;
  logic [11:0] LD_VAL;
  logic        START;
  logic        STOP;

  logic [3:0]  a_out0, a_out1, a_out2;
  logic        a_run, a_done, a_err;
  logic [3:0]  b_out0, b_out1, b_out2;
  logic        b_run, b_done, b_err;

  bcd_down_cnt3 #(.PRESCALE(1)) dut (
    .CLK0(CLK0), .RST(RST), .LOAD(LOAD), .LD_VAL(LD_VAL),
    .START(START), .STOP(STOP),
    .out0(a_out0), .out1(a_out1), .out2(a_out2),
    .RUN(a_run), .DONE(a_done), .ERR(a_err)
  );

  bcd_down_cnt3 #(.PRESCALE(4)) dut4 (
    .CLK0(CLK0), .RST(RST), .LOAD(LOAD), .LD_VAL(LD_VAL),
    .START(START), .STOP(STOP),
    .out0(b_out0), .out1(b_out1), .out2(b_out2),
    .RUN(b_run), .DONE(b_done), .ERR(b_err)
  );

  initial CLK0 = 1'b0;
  always #5 CLK0 = ~CLK0;

  typedef struct {
    bit          sel;    // 0: PRESCALE=1 instance, 1: PRESCALE=4 instance
    logic [14:0] word;   // {value[11:0], run, done, err}
    string       name;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [14:0] act,
                       input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got val=%h run=%b done=%b err=%b, expected val=%h run=%b done=%b err=%b",
               name, act[14:3], act[2], act[1], act[0],
               exp[14:3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic logic [14:0] word_a();
    return {a_out2, a_out1, a_out0, a_run, a_done, a_err};
  endfunction

  function automatic logic [14:0] word_b();
    return {b_out2, b_out1, b_out0, b_run, b_done, b_err};
  endfunction

  function automatic logic [11:0] to_bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // Monitor: compare every queued expectation right after the rising edge.
  initial begin
    item_t it;
    forever begin
      @(posedge CLK0);
      #1;
      while (sb.size() > 0) begin
        it = sb.pop_front();
        check(it.name, it.sel ? word_b() : word_a(), it.word);
      end
    end
  end

  // Apply one cycle of inputs on the falling edge.
  task automatic drive(input logic ld, input logic [11:0] v,
                       input logic st, input logic sp);
    @(negedge CLK0);
    LOAD   = ld;
    LD_VAL = v;
    START  = st;
    STOP   = sp;
  endtask

  task automatic idle();
    drive(1'b0, 12'h000, 1'b0, 1'b0);
  endtask

  // Expected outputs after the coming rising edge.
  task automatic exp_a(input logic [11:0] v, input logic r, input logic d,
                       input logic e, input string nm);
    item_t it;
    it.sel  = 1'b0;
    it.word = {v, r, d, e};
    it.name = nm;
    sb.push_back(it);
  endtask

  task automatic exp_b(input logic [11:0] v, input logic r, input logic d,
                       input logic e, input string nm);
    item_t it;
    it.sel  = 1'b1;
    it.word = {v, r, d, e};
    it.name = nm;
    sb.push_back(it);
  endtask

  initial begin
    RST    = 1'b0;
    LOAD   = 1'b0;
    LD_VAL = 12'h000;
    START  = 1'b0;
    STOP   = 1'b0;

    // Reset state, sampled while reset is held.
    @(negedge CLK0);
    check("reset_a", word_a(), 15'h0000);
    check("reset_b", word_b(), 15'h0000);
    RST = 1'b1;

    // Rejected LOAD from reset: ERR for one cycle, value stays 000.
    drive(1'b1, 12'h0A3, 1'b0, 1'b0); exp_a(12'h000, 0, 0, 1, "bad_load_err");
    idle();                           exp_a(12'h000, 0, 0, 0, "bad_load_clear");
    // START with value 000 is ignored.
    drive(1'b0, 12'h000, 1'b1, 1'b0); exp_a(12'h000, 0, 0, 0, "start_at_zero");
    idle();                           exp_a(12'h000, 0, 0, 0, "start_at_zero_hold");

    // Full countdown 105 -> 000 with the double borrow at 100 -> 099.
    drive(1'b1, 12'h105, 1'b0, 1'b0); exp_a(12'h105, 0, 0, 0, "load_105");
    drive(1'b0, 12'h000, 1'b1, 1'b0); exp_a(12'h105, 1, 0, 0, "start_105");
    for (int n = 104; n >= 0; n--) begin
      idle();
      if (n != 0) begin
        exp_a(to_bcd(n), 1, 0, 0, "countdown");
      end else begin
`ifdef AUTO_RELOAD_EN
        exp_a(12'h105, 1, 1, 0, "expiry_reload");
`else
        exp_a(12'h000, 0, 1, 0, "expiry");
`endif
      end
    end
`ifdef AUTO_RELOAD_EN
    idle(); exp_a(12'h104, 1, 0, 0, "after_reload");
`else
    idle(); exp_a(12'h000, 0, 0, 0, "zero_hold");
    drive(1'b0, 12'h000, 1'b1, 1'b0); exp_a(12'h000, 0, 0, 0, "zero_start_ignored");
`endif

    // Pause and resume: 020 -> 015, hold 10 cycles, resume -> 014.
    drive(1'b1, 12'h020, 1'b0, 1'b0); exp_a(12'h020, 0, 0, 0, "load_020");
    drive(1'b0, 12'h000, 1'b1, 1'b0); exp_a(12'h020, 1, 0, 0, "start_020");
    for (int n = 19; n >= 15; n--) begin
      idle(); exp_a(to_bcd(n), 1, 0, 0, "run_to_015");
    end
    drive(1'b0, 12'h000, 1'b0, 1'b1); exp_a(12'h015, 0, 0, 0, "stop");
    for (int i = 0; i < 10; i++) begin
      idle(); exp_a(12'h015, 0, 0, 0, "paused_hold");
    end
    drive(1'b0, 12'h000, 1'b1, 1'b0); exp_a(12'h015, 1, 0, 0, "resume");
    idle();                           exp_a(12'h014, 1, 0, 0, "resume_tick");
    // START+STOP together while running: STOP wins.
    drive(1'b0, 12'h000, 1'b1, 1'b1); exp_a(12'h014, 0, 0, 0, "start_stop");
    idle();                           exp_a(12'h014, 0, 0, 0, "start_stop_hold");
    drive(1'b0, 12'h000, 1'b1, 1'b0); exp_a(12'h014, 1, 0, 0, "restart");
    idle();                           exp_a(12'h013, 1, 0, 0, "restart_tick");

    // LOAD beats STOP; a rejected LOAD while running freezes the count.
    drive(1'b1, 12'h300, 1'b0, 1'b1); exp_a(12'h300, 0, 0, 0, "load_over_stop");
    drive(1'b0, 12'h000, 1'b1, 1'b0); exp_a(12'h300, 1, 0, 0, "start_300");
    drive(1'b1, 12'h2B0, 1'b0, 1'b0); exp_a(12'h300, 1, 0, 1, "bad_load_running");
    idle();                           exp_a(12'h299, 1, 0, 0, "after_bad_load");
    drive(1'b1, 12'h000, 1'b0, 1'b0); exp_a(12'h000, 0, 0, 0, "load_000");
    drive(1'b0, 12'h000, 1'b1, 1'b0); exp_a(12'h000, 0, 0, 0, "start_000_ignored");

    // PRESCALE=4: one decrement per four edges, then reset mid-prescale.
    drive(1'b1, 12'h057, 1'b0, 1'b0); exp_b(12'h057, 0, 0, 0, "p4_load_057");
    drive(1'b0, 12'h000, 1'b1, 1'b0); exp_b(12'h057, 1, 0, 0, "p4_start");
    for (int i = 0; i < 3; i++) begin
      idle(); exp_b(12'h057, 1, 0, 0, "p4_prescale_wait");
    end
    idle(); exp_b(12'h056, 1, 0, 0, "p4_first_tick");
    idle(); exp_b(12'h056, 1, 0, 0, "p4_mid_prescale");
    @(negedge CLK0);
    RST = 1'b0;
    #1;
    check("async_reset_b", word_b(), 15'h0000);
    check("async_reset_a", word_a(), 15'h0000);
    @(negedge CLK0);
    RST   = 1'b1;
    START = 1'b1;
    exp_b(12'h000, 0, 0, 0, "p4_start_after_reset");
    exp_a(12'h000, 0, 0, 0, "start_after_reset");

    // PRESCALE=4 expiry from 002: tick on every fourth edge.
    drive(1'b1, 12'h002, 1'b0, 1'b0); exp_b(12'h002, 0, 0, 0, "p4_load_002");
    drive(1'b0, 12'h000, 1'b1, 1'b0); exp_b(12'h002, 1, 0, 0, "p4_start_002");
    for (int i = 0; i < 3; i++) begin
      idle(); exp_b(12'h002, 1, 0, 0, "p4_wait_002");
    end
    idle(); exp_b(12'h001, 1, 0, 0, "p4_tick_001");
    for (int i = 0; i < 3; i++) begin
      idle(); exp_b(12'h001, 1, 0, 0, "p4_wait_001");
    end
`ifdef AUTO_RELOAD_EN
    idle(); exp_b(12'h002, 1, 1, 0, "p4_expiry_reload");
    idle(); exp_b(12'h002, 1, 0, 0, "p4_after_reload");
`else
    idle(); exp_b(12'h000, 0, 1, 0, "p4_expiry");
    idle(); exp_b(12'h000, 0, 0, 0, "p4_done_clear");
`endif

`ifdef AUTO_RELOAD_EN
    // Auto-reload with a short start value.
    drive(1'b1, 12'h003, 1'b0, 1'b0); exp_a(12'h003, 0, 0, 0, "ar_load_003");
    drive(1'b0, 12'h000, 1'b1, 1'b0); exp_a(12'h003, 1, 0, 0, "ar_start");
    idle(); exp_a(12'h002, 1, 0, 0, "ar_002");
    idle(); exp_a(12'h001, 1, 0, 0, "ar_001");
    idle(); exp_a(12'h003, 1, 1, 0, "ar_reload");
    idle(); exp_a(12'h002, 1, 0, 0, "ar_continue");
`endif

    idle();
    @(posedge CLK0);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
